// File: rtl/clk_div_ctrl.sv
// Programmable divide-by-N controller: registered divided clock, terminal tick and a
// valid/ready divisor interface whose new values take effect only at period boundaries.
module clk_div_ctrl #(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         div_clk_out,
    output logic         tick,
    output logic         busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] ZERO    = {W{1'b0}};
    localparam logic [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TWO     = {{(W-2){1'b0}}, 2'b10};
    localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);

    state_t         state_r, state_s;
    logic [W-1:0]   cnt_r, cnt_s;
    logic [W-1:0]   n_act_r, n_act_s;
    logic [W-1:0]   pend_div_r, pend_div_s;
    logic           pend_vld_r, pend_vld_s;
    logic           div_clk_r, div_clk_s;
    logic           tick_r, tick_s;
    logic           busy_r, busy_s;
    logic           cfg_ready_r, cfg_ready_s;
    logic           cfg_err_r, cfg_err_s;
    logic           term_s;
    logic           xfer_s;
    logic           apply_s;

    // Terminal count decode and handshake transfer, from registered state only.
    always_comb begin
        term_s = (state_r == RUN) && (cnt_r == (n_act_r - ONE));
        xfer_s = cfg_valid && cfg_ready_r;
    end

    // Next-state, counter, divisor apply/capture and next output values.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        n_act_s    = n_act_r;
        pend_div_s = pend_div_r;
        pend_vld_s = pend_vld_r;
        apply_s    = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_s   = ZERO;
                apply_s = pend_vld_r;
                if (en) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (en) begin
                    state_s = RUN;
                    if (term_s) begin
                        cnt_s   = ZERO;
                        apply_s = pend_vld_r;
                    end else begin
                        cnt_s = cnt_r + ONE;
                    end
                end else begin
                    // Dropping en truncates the period; a pending divisor lands with IDLE entry.
                    state_s = IDLE;
                    cnt_s   = ZERO;
                    apply_s = pend_vld_r;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = ZERO;
            end
        endcase

        if (apply_s) begin
            n_act_s    = pend_div_r;
            pend_vld_s = 1'b0;
        end else begin
            n_act_s = n_act_r;
        end

        // Capture happens after apply so a same-edge transfer waits for the next boundary.
        if (xfer_s && (cfg_div >= TWO)) begin
            pend_div_s = cfg_div;
            pend_vld_s = 1'b1;
        end else begin
            pend_div_s = pend_div_s;
        end

        cfg_err_s   = xfer_s && (cfg_div < TWO);
        busy_s      = (state_s == RUN);
        div_clk_s   = busy_s && (cnt_s < (n_act_s >> 1));
        tick_s      = busy_s && (cnt_s == (n_act_s - ONE));
        cfg_ready_s = !pend_vld_s;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= ZERO;
            n_act_r     <= DEF_DIV;
            pend_div_r  <= ZERO;
            pend_vld_r  <= 1'b0;
            div_clk_r   <= 1'b0;
            tick_r      <= 1'b0;
            busy_r      <= 1'b0;
            cfg_ready_r <= 1'b1;
            cfg_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            n_act_r     <= n_act_s;
            pend_div_r  <= pend_div_s;
            pend_vld_r  <= pend_vld_s;
            div_clk_r   <= div_clk_s;
            tick_r      <= tick_s;
            busy_r      <= busy_s;
            cfg_ready_r <= cfg_ready_s;
            cfg_err_r   <= cfg_err_s;
        end
    end

    assign div_clk_out = div_clk_r;
    assign tick        = tick_r;
    assign busy        = busy_r;
    assign cfg_ready   = cfg_ready_r;
    assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period/phase reference model pushes the expected
// outputs of every cycle into a queue; a negedge monitor pops and compares.
module tb_clk_div_ctrl;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic       div_clk_out;
    logic       tick;
    logic       busy;

    clk_div_ctrl #(.W(8), .DEFAULT_DIV(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .div_clk_out(div_clk_out),
        .tick       (tick),
        .busy       (busy)
    );

    typedef struct packed {
        logic div;
        logic tck;
        logic bsy;
        logic rdy;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    // Reference model: running flag, divisor, phase within period, pending divisor list.
    bit   m_run;
    int   m_n;
    int   m_phase;
    int   m_pend[$];
    bit   m_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_run   = 1'b0;
        m_n     = 4;
        m_phase = 0;
        m_pend.delete();
        m_err   = 1'b0;
    endfunction

    function automatic void model_step(input bit e, input bit v, input int d);
        bit accept;
        bit last;
        accept = v && (m_pend.size() == 0);
        last   = m_run && (m_phase == m_n - 1);
        m_err  = accept && (d < 2);
        if (m_pend.size() != 0 && (!m_run || !e || last))
            m_n = m_pend.pop_front();
        if (e && m_run && !last)
            m_phase = m_phase + 1;
        else
            m_phase = 0;
        m_run = e;
        if (accept && d >= 2)
            m_pend.push_back(d);
    endfunction

    function automatic exp_t model_out();
        exp_t x;
        x.div = m_run && (m_phase < m_n / 2);
        x.tck = m_run && (m_phase == m_n - 1);
        x.bsy = m_run;
        x.rdy = (m_pend.size() == 0);
        x.err = m_err;
        return x;
    endfunction

    // One clock: model consumes the inputs seen at this edge, then new inputs are driven.
    task automatic cyc(input bit e, input bit v, input int d, input bit rst);
        @(posedge clk);
        if (rst) begin
            model_reset();
            exp_q.push_back(model_out());
            #2;
            reset_n = 1'b0;
        end else if (!reset_n) begin
            model_reset();
            exp_q.push_back(model_out());
            #2;
            reset_n = 1'b1;
        end else begin
            model_step(en, cfg_valid, int'(cfg_div));
            exp_q.push_back(model_out());
            #2;
        end
        en        = e;
        cfg_valid = v;
        cfg_div   = 8'(d);
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle on the falling edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("div_clk_out", div_clk_out, x.div);
                chk("tick", tick, x.tck);
                chk("busy", busy, x.bsy);
                chk("cfg_ready", cfg_ready, x.rdy);
                chk("cfg_err", cfg_err, x.err);
            end
        end
    end

    initial begin
        int  d;
        bit  e;
        reset_n   = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = 8'd0;
        model_reset();

        // Reset release, then default divide-by-4 running.
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 0, 1'b0);
        // Wait for phase 0, then offer 3 at phase 1 of a period.
        while (!(m_run && m_phase == 0)) cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 3, 1'b0);
        repeat (12) cyc(1'b1, 1'b0, 0, 1'b0);
        // Illegal divisors 0 and 1.
        cyc(1'b1, 1'b1, 0, 1'b0);
        cyc(1'b1, 1'b1, 1, 1'b0);
        repeat (8) cyc(1'b1, 1'b0, 0, 1'b0);
        // Divide by 255 loaded in IDLE.
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b1, 255, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b0);
        repeat (560) cyc(1'b1, 1'b0, 0, 1'b0);
        // Pending 6 then reset mid-period.
        cyc(1'b1, 1'b1, 6, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 1'b1);
        cyc(1'b1, 1'b0, 0, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 0, 1'b0);
        // Transfer of 2 on a tick cycle.
        while (!(m_run && m_phase == m_n - 2)) cyc(1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 2, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 0, 1'b0);
        // Drop en with a divisor pending.
        cyc(1'b1, 1'b1, 5, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 0, 1'b0);
        repeat (12) cyc(1'b1, 1'b0, 0, 1'b0);

        // Randomized traffic with occasional en flips, illegal divisors and resets.
        e = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 2) e = !e;
            case ($urandom_range(0, 5))
                0:       d = $urandom_range(0, 1);
                1:       d = 255;
                2:       d = $urandom_range(0, 255);
                default: d = $urandom_range(2, 12);
            endcase
            cyc(e, ($urandom_range(0, 99) < 10), d, ($urandom_range(0, 999) < 2));
        end
        cyc(1'b0, 1'b0, 0, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
